// File: rtl/holosynth_pkg.sv
// Shared definitions for the holosynth voice allocator.
//   state_t   : allocator FSM states
//   GATE_ON / GATE_OFF : values carried on asg_gate
//   CLOG2     : ceiling log2, used to size voice indices and counts
package holosynth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_EMIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    localparam logic GATE_ON  = 1'b1;
    localparam logic GATE_OFF = 1'b0;

    function automatic int CLOG2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/holosynth_popcount.sv
// Registered population count.
//   clk, rst_n : clock, asynchronous active-low reset
//   bits       : N-bit input vector
//   count      : number of set bits, registered (one cycle behind bits)
module holosynth_popcount
    import holosynth_pkg::*;
#(
    parameter int N     = 32,
    parameter int OUT_W = CLOG2(N) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     bits,
    output logic [OUT_W-1:0] count
);

    logic [OUT_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + OUT_W'(bits[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= sum;
    end

endmodule

// File: rtl/holosynth_voice_alloc.sv
// Polyphonic voice allocator: maps note-on/off events to voice slots.
//   reg_clk, reset_reg_n : clock, asynchronous active-low reset
//   ev_*                 : MIDI event in (valid/ready); note-on with vel 0 acts as note-off
//   sustain              : sustain pedal level; falling edge releases sustained voices
//   voice_done           : per-voice pulse from the envelope engine, frees the slot
//   asg_*                : assignment command out (valid/ready), held until accepted
//   keys_on, voice_free  : per-voice gate and free flags
//   active_keys          : registered popcount of keys_on
//   drop_cnt             : saturating count of dropped note-ons
// Every event is resolved by a fixed NUM_VOICES-cycle scan over all slots, so
// the accept-to-command latency does not depend on voice state.
module holosynth_voice_alloc
    import holosynth_pkg::*;
#(
    parameter int NUM_VOICES = 32,
    parameter int V_WIDTH    = CLOG2(NUM_VOICES),
    parameter int KEY_W      = 7,
    parameter int VEL_W      = 7,
    parameter int AGE_W      = 8,
    parameter bit STEAL_EN   = 1'b1
) (
    input  logic                  reg_clk,
    input  logic                  reset_reg_n,
    input  logic                  ev_valid,
    output logic                  ev_ready,
    input  logic                  ev_note_on,
    input  logic [KEY_W-1:0]      ev_key,
    input  logic [VEL_W-1:0]      ev_vel,
    input  logic                  sustain,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic                  asg_valid,
    input  logic                  asg_ready,
    output logic [V_WIDTH-1:0]    asg_voice,
    output logic [KEY_W-1:0]      asg_key,
    output logic [VEL_W-1:0]      asg_vel,
    output logic                  asg_gate,
    output logic                  asg_steal,
    output logic [NUM_VOICES-1:0] keys_on,
    output logic [NUM_VOICES-1:0] voice_free,
    output logic [V_WIDTH:0]      active_keys,
    output logic [15:0]           drop_cnt
);

    localparam logic [V_WIDTH-1:0] LAST    = V_WIDTH'(NUM_VOICES - 1);
    localparam logic [AGE_W-1:0]   AGE_MAX = '1;

    state_t state;
    logic [V_WIDTH-1:0] idx;

    // latched event
    logic             ev_on_q;
    logic [KEY_W-1:0] ev_key_q;
    logic [VEL_W-1:0] ev_vel_q;

    logic sustain_q, flush_pend, sus_fall;

    // per-voice state
    logic [NUM_VOICES-1:0][KEY_W-1:0] v_key;
    logic [NUM_VOICES-1:0][VEL_W-1:0] v_vel;
    logic [NUM_VOICES-1:0][AGE_W-1:0] v_age;
    logic [NUM_VOICES-1:0]            v_busy, v_gate, v_sust;

    // scan candidates: same-key busy, first free, oldest released, oldest gated, note-off target
    logic               same_f, free_f, off_f, gat_f, noff_f;
    logic [V_WIDTH-1:0] same_i, free_i, off_i, gat_i, noff_i;
    logic [AGE_W-1:0]   off_age, gat_age;
    logic               nxt_same_f, nxt_free_f, nxt_off_f, nxt_gat_f, nxt_noff_f;
    logic [V_WIDTH-1:0] nxt_same_i, nxt_free_i, nxt_off_i, nxt_gat_i, nxt_noff_i;
    logic [AGE_W-1:0]   nxt_off_age, nxt_gat_age;

    // decision at the last scan step
    logic               scan_last, dec_emit, dec_gate, dec_steal, dec_drop, set_sust;
    logic [V_WIDTH-1:0] dec_voice;

    logic hs, commit_on, commit_off;

    assign ev_ready   = (state == ST_IDLE) && !flush_pend;
    assign sus_fall   = sustain_q && !sustain;
    assign hs         = asg_valid && asg_ready;
    assign commit_on  = hs && (asg_gate == GATE_ON);
    assign commit_off = hs && (asg_gate == GATE_OFF);
    assign keys_on    = v_gate;
    assign voice_free = ~v_busy;
    assign scan_last  = (state == ST_SCAN) && (idx == LAST);

    // Fold voice[idx] into the running candidates. Strict '>' on age keeps the
    // lowest index on ties because the scan runs upward.
    always_comb begin
        nxt_same_f = same_f;  nxt_same_i = same_i;
        nxt_free_f = free_f;  nxt_free_i = free_i;
        nxt_off_f  = off_f;   nxt_off_i  = off_i;  nxt_off_age = off_age;
        nxt_gat_f  = gat_f;   nxt_gat_i  = gat_i;  nxt_gat_age = gat_age;
        nxt_noff_f = noff_f;  nxt_noff_i = noff_i;
        if (v_busy[idx] && !same_f && v_key[idx] == ev_key_q) begin
            nxt_same_f = 1'b1;  nxt_same_i = idx;
        end
        if (!v_busy[idx] && !free_f) begin
            nxt_free_f = 1'b1;  nxt_free_i = idx;
        end
        if (v_busy[idx] && !v_gate[idx] && (!off_f || v_age[idx] > off_age)) begin
            nxt_off_f = 1'b1;  nxt_off_i = idx;  nxt_off_age = v_age[idx];
        end
        if (v_busy[idx] && v_gate[idx] && (!gat_f || v_age[idx] > gat_age)) begin
            nxt_gat_f = 1'b1;  nxt_gat_i = idx;  nxt_gat_age = v_age[idx];
        end
        if (v_gate[idx] && !noff_f && v_key[idx] == ev_key_q) begin
            nxt_noff_f = 1'b1;  nxt_noff_i = idx;
        end
    end

    always_comb begin
        dec_emit  = 1'b0;
        dec_voice = '0;
        dec_gate  = GATE_OFF;
        dec_steal = 1'b0;
        dec_drop  = 1'b0;
        set_sust  = 1'b0;
        if (scan_last) begin
            if (ev_on_q) begin
                dec_gate = GATE_ON;
                if (nxt_same_f) begin
                    dec_emit = 1'b1;  dec_voice = nxt_same_i;
                end else if (nxt_free_f) begin
                    dec_emit = 1'b1;  dec_voice = nxt_free_i;
                end else if (STEAL_EN && nxt_off_f) begin
                    dec_emit = 1'b1;  dec_voice = nxt_off_i;  dec_steal = 1'b1;
                end else if (STEAL_EN && nxt_gat_f) begin
                    dec_emit = 1'b1;  dec_voice = nxt_gat_i;  dec_steal = 1'b1;
                end else begin
                    dec_drop = 1'b1;
                end
            end else if (nxt_noff_f) begin
                // held pedal defers the release to the flush walk
                if (sustain) set_sust = 1'b1;
                else begin
                    dec_emit = 1'b1;  dec_voice = nxt_noff_i;
                end
            end
        end
    end

    // Per-voice state. A gate-on commit outranks a same-cycle voice_done on
    // the same slot, so the freshly triggered voice stays busy.
    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            v_key  <= '0;
            v_vel  <= '0;
            v_age  <= '0;
            v_busy <= '0;
            v_gate <= '0;
            v_sust <= '0;
        end else begin
            for (int j = 0; j < NUM_VOICES; j++) begin
                if (commit_on && asg_voice == V_WIDTH'(j)) begin
                    v_key[j]  <= asg_key;
                    v_vel[j]  <= asg_vel;
                    v_age[j]  <= '0;
                    v_busy[j] <= 1'b1;
                    v_gate[j] <= 1'b1;
                    v_sust[j] <= 1'b0;
                end else begin
                    if (commit_on && v_busy[j] && v_age[j] != AGE_MAX)
                        v_age[j] <= v_age[j] + 1'b1;
                    if (commit_off && asg_voice == V_WIDTH'(j)) begin
                        v_gate[j] <= 1'b0;
                        v_sust[j] <= 1'b0;
                    end
                    if (set_sust && nxt_noff_i == V_WIDTH'(j))
                        v_sust[j] <= 1'b1;
                    // a freed slot must not be released again by a later flush
                    if (voice_done[j]) begin
                        v_busy[j] <= 1'b0;
                        v_gate[j] <= 1'b0;
                        v_sust[j] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge reg_clk or negedge reset_reg_n) begin
        if (!reset_reg_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            ev_on_q    <= 1'b0;
            ev_key_q   <= '0;
            ev_vel_q   <= '0;
            sustain_q  <= 1'b0;
            flush_pend <= 1'b0;
            same_f <= 1'b0;  same_i <= '0;
            free_f <= 1'b0;  free_i <= '0;
            off_f  <= 1'b0;  off_i  <= '0;  off_age <= '0;
            gat_f  <= 1'b0;  gat_i  <= '0;  gat_age <= '0;
            noff_f <= 1'b0;  noff_i <= '0;
            asg_valid <= 1'b0;
            asg_voice <= '0;
            asg_key   <= '0;
            asg_vel   <= '0;
            asg_gate  <= 1'b0;
            asg_steal <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            sustain_q <= sustain;
            case (state)
                ST_IDLE: begin
                    if (flush_pend) begin
                        state      <= ST_FLUSH;
                        idx        <= '0;
                        flush_pend <= 1'b0;
                    end else if (ev_valid) begin
                        ev_on_q  <= ev_note_on && (ev_vel != '0);
                        ev_key_q <= ev_key;
                        ev_vel_q <= ev_vel;
                        idx      <= '0;
                        same_f <= 1'b0;  free_f <= 1'b0;  off_f <= 1'b0;
                        gat_f  <= 1'b0;  noff_f <= 1'b0;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    same_f <= nxt_same_f;  same_i <= nxt_same_i;
                    free_f <= nxt_free_f;  free_i <= nxt_free_i;
                    off_f  <= nxt_off_f;   off_i  <= nxt_off_i;  off_age <= nxt_off_age;
                    gat_f  <= nxt_gat_f;   gat_i  <= nxt_gat_i;  gat_age <= nxt_gat_age;
                    noff_f <= nxt_noff_f;  noff_i <= nxt_noff_i;
                    if (idx == LAST) begin
                        if (dec_emit) begin
                            asg_valid <= 1'b1;
                            asg_voice <= dec_voice;
                            asg_key   <= ev_key_q;
                            asg_vel   <= ev_vel_q;
                            asg_gate  <= dec_gate;
                            asg_steal <= dec_steal;
                            state     <= ST_EMIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                        if (dec_drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_EMIT: begin
                    if (asg_ready) begin
                        asg_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    // one release command per sustained voice, walked in index order
                    if (asg_valid) begin
                        if (asg_ready) begin
                            asg_valid <= 1'b0;
                            if (idx == LAST) state <= ST_IDLE;
                            else             idx   <= idx + 1'b1;
                        end
                    end else if (v_sust[idx]) begin
                        asg_valid <= 1'b1;
                        asg_voice <= idx;
                        asg_key   <= v_key[idx];
                        asg_vel   <= v_vel[idx];
                        asg_gate  <= GATE_OFF;
                        asg_steal <= 1'b0;
                    end else if (idx == LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // a pedal release seen in any state re-arms the flush
            if (sus_fall) flush_pend <= 1'b1;
        end
    end

    holosynth_popcount #(.N(NUM_VOICES), .OUT_W(V_WIDTH + 1)) u_popcount (
        .clk   (reg_clk),
        .rst_n (reset_reg_n),
        .bits  (v_gate),
        .count (active_keys)
    );

endmodule

// File: tb/tb_holosynth_voice_alloc.sv
module tb_holosynth_voice_alloc;

    localparam int NV = 32;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (steal enabled, 32 voices)
    logic          ev_valid = 1'b0, ev_ready, ev_note_on = 1'b0;
    logic [6:0]    ev_key = '0, ev_vel = '0;
    logic          sustain = 1'b0;
    logic [NV-1:0] voice_done = '0;
    logic          asg_valid, asg_ready = 1'b1;
    logic [4:0]    asg_voice;
    logic [6:0]    asg_key, asg_vel;
    logic          asg_gate, asg_steal;
    logic [NV-1:0] keys_on, voice_free;
    logic [5:0]    active_keys;
    logic [15:0]   drop_cnt;

    // second instance: no stealing, 4 voices
    logic          b_ev_valid = 1'b0, b_ev_ready, b_ev_note_on = 1'b0;
    logic [6:0]    b_ev_key = '0, b_ev_vel = '0;
    logic          b_sustain = 1'b0;
    logic [NB-1:0] b_voice_done = '0;
    logic          b_asg_valid, b_asg_ready = 1'b1;
    logic [1:0]    b_asg_voice;
    logic [6:0]    b_asg_key, b_asg_vel;
    logic          b_asg_gate, b_asg_steal;
    logic [NB-1:0] b_keys_on, b_voice_free;
    logic [2:0]    b_active_keys;
    logic [15:0]   b_drop_cnt;

    holosynth_voice_alloc #(.NUM_VOICES(NV)) dut (
        .reg_clk(clk), .reset_reg_n(rst_n),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_note_on(ev_note_on),
        .ev_key(ev_key), .ev_vel(ev_vel), .sustain(sustain), .voice_done(voice_done),
        .asg_valid(asg_valid), .asg_ready(asg_ready), .asg_voice(asg_voice),
        .asg_key(asg_key), .asg_vel(asg_vel), .asg_gate(asg_gate), .asg_steal(asg_steal),
        .keys_on(keys_on), .voice_free(voice_free), .active_keys(active_keys),
        .drop_cnt(drop_cnt)
    );

    holosynth_voice_alloc #(.NUM_VOICES(NB), .STEAL_EN(1'b0)) dut_ns (
        .reg_clk(clk), .reset_reg_n(rst_n),
        .ev_valid(b_ev_valid), .ev_ready(b_ev_ready), .ev_note_on(b_ev_note_on),
        .ev_key(b_ev_key), .ev_vel(b_ev_vel), .sustain(b_sustain), .voice_done(b_voice_done),
        .asg_valid(b_asg_valid), .asg_ready(b_asg_ready), .asg_voice(b_asg_voice),
        .asg_key(b_asg_key), .asg_vel(b_asg_vel), .asg_gate(b_asg_gate), .asg_steal(b_asg_steal),
        .keys_on(b_keys_on), .voice_free(b_voice_free), .active_keys(b_active_keys),
        .drop_cnt(b_drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] voice;
        logic [6:0] key;
        logic [6:0] vel;
        logic       gate;
        logic       steal;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   b_asg_cnt = 0;

    function automatic void expect_asg(input int v, input int k, input int vl, input bit g, input bit s);
        exp_t t;
        t.voice = 5'(v);
        t.key   = 7'(k);
        t.vel   = 7'(vl);
        t.gate  = g;
        t.steal = s;
        exp_q.push_back(t);
    endfunction

    // Scoreboard: every accepted command must match the oldest expectation.
    // Velocity is compared for gate-on only; a release carries no velocity meaning.
    always @(negedge clk) begin
        if (rst_n && asg_valid && asg_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL asg_unexpected got voice=%0d key=%0d gate=%0b steal=%0b",
                         asg_voice, asg_key, asg_gate, asg_steal);
            end else begin
                mon_e = exp_q.pop_front();
                if (asg_voice !== mon_e.voice || asg_key !== mon_e.key || asg_gate !== mon_e.gate ||
                    asg_steal !== mon_e.steal || (mon_e.gate && asg_vel !== mon_e.vel)) begin
                    failures++;
                    $display("FAIL asg_cmd got voice=%0d key=%0d vel=%0d gate=%0b steal=%0b want voice=%0d key=%0d vel=%0d gate=%0b steal=%0b",
                             asg_voice, asg_key, asg_vel, asg_gate, asg_steal,
                             mon_e.voice, mon_e.key, mon_e.vel, mon_e.gate, mon_e.steal);
                end
            end
        end
    end

    always @(negedge clk) if (rst_n && b_asg_valid) b_asg_cnt++;

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        ev_valid = 1'b0;  b_ev_valid = 1'b0;
        sustain = 1'b0;   voice_done = '0;
        asg_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input bit which, input bit on, input int key, input int vel);
        int n;
        @(posedge clk); #1;
        if (which) begin
            b_ev_valid = 1'b1; b_ev_note_on = on; b_ev_key = 7'(key); b_ev_vel = 7'(vel);
        end else begin
            ev_valid = 1'b1; ev_note_on = on; ev_key = 7'(key); ev_vel = 7'(vel);
        end
        n = 0;
        @(negedge clk);
        while (!(which ? b_ev_ready : ev_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL ev_accept got ev_ready=0 want ev_ready=1 within 500 cycles");
        end
        @(posedge clk); #1;
        ev_valid = 1'b0;
        b_ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit which);
        int n;
        n = 0;
        repeat (2) @(negedge clk);
        while (!(which ? (b_ev_ready && !b_asg_valid) : (ev_ready && !asg_valid)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            failures++;
            $display("FAIL idle_timeout got busy want idle within 500 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_q_empty(input string tag);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_pending got %0d outstanding want 0", tag, exp_q.size());
        end
    endtask

    task automatic test_reset();
        int k;
        do_reset();
        checks++;
        if (voice_free !== {NV{1'b1}} || keys_on !== '0 || active_keys !== '0 || drop_cnt !== '0 ||
            asg_valid !== 1'b0 || asg_voice !== '0 || asg_gate !== 1'b0 || asg_steal !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got free=%h on=%h act=%0d drop=%0d av=%0b want free=ffffffff on=0 act=0 drop=0 av=0",
                     voice_free, keys_on, active_keys, drop_cnt, asg_valid);
        end
        checks++;
        if (ev_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ev_ready got %0b want 1", ev_ready);
        end
        expect_asg(0, 60, 100, 1'b1, 1'b0);
        send(1'b0, 1'b1, 60, 100);
        // send returns just after the accepting edge; NV scan edges follow,
        // so asg_valid shows in the (NV+1)th cycle counting the accept cycle
        k = 0;
        while (!asg_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (k != NV) begin
            failures++;
            $display("FAIL latency got %0d edges want %0d", k, NV);
        end
        wait_idle(1'b0);
        checks++;
        if (active_keys !== 6'd1 || keys_on !== 32'h1 || voice_free !== ~32'h1) begin
            failures++;
            $display("FAIL first_note got act=%0d on=%h free=%h want act=1 on=1 free=fffffffe",
                     active_keys, keys_on, voice_free);
        end
        check_q_empty("reset");
    endtask

    task automatic test_steal();
        int base;
        do_reset();
        for (int i = 0; i < NV; i++) begin
            expect_asg(i, 20 + i, 50, 1'b1, 1'b0);
            send(1'b0, 1'b1, 20 + i, 50);
            wait_idle(1'b0);
        end
        // all gated; voice 0 was triggered first so it is the oldest
        expect_asg(0, 90, 77, 1'b1, 1'b1);
        send(1'b0, 1'b1, 90, 77);
        wait_idle(1'b0);
        checks++;
        if (active_keys !== 6'd32 || keys_on !== {NV{1'b1}}) begin
            failures++;
            $display("FAIL full_count got act=%0d on=%h want act=32 on=ffffffff", active_keys, keys_on);
        end
        check_q_empty("steal");

        base = b_asg_cnt;
        for (int i = 0; i < NB; i++) begin
            send(1'b1, 1'b1, 30 + i, 40);
            wait_idle(1'b1);
        end
        checks++;
        if (b_asg_cnt - base != NB) begin
            failures++;
            $display("FAIL nosteal_fill got %0d cmds want %0d", b_asg_cnt - base, NB);
        end
        send(1'b1, 1'b1, 40, 40);
        wait_idle(1'b1);
        checks++;
        if (b_drop_cnt !== 16'd1 || b_asg_cnt - base != NB || b_keys_on !== 4'hF) begin
            failures++;
            $display("FAIL nosteal_drop got drop=%0d cmds=%0d on=%h want drop=1 cmds=4 on=f",
                     b_drop_cnt, b_asg_cnt - base, b_keys_on);
        end
    endtask

    task automatic test_sustain();
        do_reset();
        @(posedge clk); #1;
        sustain = 1'b1;
        expect_asg(0, 60, 100, 1'b1, 1'b0);
        send(1'b0, 1'b1, 60, 100);
        wait_idle(1'b0);
        send(1'b0, 1'b0, 60, 64);
        wait_idle(1'b0);
        checks++;
        if (keys_on[0] !== 1'b1 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL sustain_hold got on0=%0b pending=%0d want on0=1 pending=0", keys_on[0], exp_q.size());
        end
        expect_asg(0, 60, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        sustain = 1'b0;
        wait_idle(1'b0);
        checks++;
        if (keys_on !== '0 || active_keys !== '0 || voice_free[0] !== 1'b0) begin
            failures++;
            $display("FAIL sustain_flush got on=%h act=%0d free0=%0b want on=0 act=0 free0=0",
                     keys_on, active_keys, voice_free[0]);
        end
        check_q_empty("sustain");
    endtask

    task automatic test_retrigger();
        do_reset();
        expect_asg(0, 60, 100, 1'b1, 1'b0);
        send(1'b0, 1'b1, 60, 100);
        wait_idle(1'b0);
        expect_asg(0, 60, 90, 1'b1, 1'b0);
        send(1'b0, 1'b1, 60, 90);
        wait_idle(1'b0);
        checks++;
        if (active_keys !== 6'd1) begin
            failures++;
            $display("FAIL retrigger_count got %0d want 1", active_keys);
        end
        // note-on with zero velocity releases the key
        expect_asg(1, 61, 100, 1'b1, 1'b0);
        send(1'b0, 1'b1, 61, 100);
        wait_idle(1'b0);
        expect_asg(1, 61, 0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 61, 0);
        wait_idle(1'b0);
        checks++;
        if (keys_on[1] !== 1'b0 || voice_free[1] !== 1'b0 || drop_cnt !== '0) begin
            failures++;
            $display("FAIL vel0_off got on1=%0b free1=%0b drop=%0d want on1=0 free1=0 drop=0",
                     keys_on[1], voice_free[1], drop_cnt);
        end
        @(posedge clk); #1;
        voice_done = 32'h1;
        @(posedge clk); #1;
        voice_done = '0;
        @(negedge clk);
        checks++;
        if (voice_free[0] !== 1'b1 || keys_on[0] !== 1'b0) begin
            failures++;
            $display("FAIL voice_done got free0=%0b on0=%0b want free0=1 on0=0", voice_free[0], keys_on[0]);
        end
        check_q_empty("retrigger");
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        asg_ready = 1'b0;
        expect_asg(0, 60, 100, 1'b1, 1'b0);
        send(1'b0, 1'b1, 60, 100);
        n = 0;
        while (!asg_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (asg_valid !== 1'b1 || asg_voice !== 5'd0 || asg_key !== 7'd60 || asg_vel !== 7'd100 ||
                asg_gate !== 1'b1 || asg_steal !== 1'b0 || ev_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_cycle%0d got av=%0b voice=%0d key=%0d vel=%0d gate=%0b er=%0b want av=1 voice=0 key=60 vel=100 gate=1 er=0",
                         c, asg_valid, asg_voice, asg_key, asg_vel, asg_gate, ev_ready);
            end
        end
        // asynchronous reset away from any clock edge, command still pending
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (asg_valid !== 1'b0 || voice_free !== {NV{1'b1}} || keys_on !== '0 ||
            active_keys !== '0 || drop_cnt !== '0 || asg_voice !== '0 || asg_gate !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_emit got av=%0b free=%h on=%h act=%0d want av=0 free=ffffffff on=0 act=0",
                     asg_valid, voice_free, keys_on, active_keys);
        end
        exp_q.delete();
        asg_ready = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (ev_ready !== 1'b1 || asg_valid !== 1'b0) begin
            failures++;
            $display("FAIL after_reset got er=%0b av=%0b want er=1 av=0", ev_ready, asg_valid);
        end
    endtask

    task automatic test_done_collision();
        int n;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            expect_asg(i, 10 + i, 80, 1'b1, 1'b0);
            send(1'b0, 1'b1, 10 + i, 80);
            wait_idle(1'b0);
        end
        asg_ready = 1'b0;
        expect_asg(3, 13, 80, 1'b1, 1'b0);
        send(1'b0, 1'b1, 13, 80);
        n = 0;
        while (!asg_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        asg_ready  = 1'b1;
        voice_done = 32'h8;
        @(posedge clk); #1;
        voice_done = '0;
        @(negedge clk);
        checks++;
        if (voice_free[3] !== 1'b0 || keys_on[3] !== 1'b1) begin
            failures++;
            $display("FAIL done_collision got free3=%0b on3=%0b want free3=0 on3=1", voice_free[3], keys_on[3]);
        end
        wait_idle(1'b0);
        check_q_empty("collision");
    endtask

    initial begin
        test_reset();
        test_steal();
        test_sustain();
        test_retrigger();
        test_backpressure();
        test_done_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
